trena_receptor_medida: RTL and testbench

//  Receiving end of the trena serial link: deserializes 7O1 UART frames on

---
 rtl/trena_receptor_medida.sv | 274 +++++++++++++++++++++++++++
 tb/tb_trena_receptor_medida.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trena_receptor_medida.sv
// Receiving end of the trena serial link.
// Deserializes 7O1 UART frames and assembles "DDD#" messages into three BCD digits.
// Parity, framing and message-format errors are flagged with a one-cycle pulse.
module trena_receptor_medida #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [3:0] centena,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic       medida_pronta,
    output logic       erro,
    output logic [2:0] db_estado_rx,
    output logic [1:0] db_estado_msg
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StOcioso   = 3'd0,
        StInicio   = 3'd1,
        StDados    = 3'd2,
        StParidade = 3'd3,
        StParada   = 3'd4
    } estado_rx_e;

    typedef enum logic [1:0] {
        MsgC    = 2'd0,
        MsgD    = 2'd1,
        MsgU    = 2'd2,
        MsgHash = 2'd3
    } estado_msg_e;

    // Line synchronizer
    logic sync1_q, sync2_q;
    logic linha;

    // Bit-level receiver
    estado_rx_e      estado_rx_q, estado_rx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [6:0]      dados_q, dados_d;
    logic            paridade_q, paridade_d;
    logic            parada_q, parada_d;
    logic            fim_q, fim_d;
    logic            char_ok_q, char_ok_d;
    logic            char_err_q, char_err_d;

    // Message assembler
    estado_msg_e msg_q, msg_d;
    logic [3:0]  cen_sh_q, cen_sh_d;
    logic [3:0]  dez_sh_q, dez_sh_d;
    logic [3:0]  uni_sh_q, uni_sh_d;
    logic [3:0]  cen_q, cen_d;
    logic [3:0]  dez_q, dez_d;
    logic [3:0]  uni_q, uni_d;
    logic        pronta_q, pronta_d;
    logic        erro_q, erro_d;
    logic        eh_digito, eh_hash;
    logic [3:0]  digito;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= entrada_serial;
            sync2_q <= sync1_q;
        end
    end

    assign linha = sync2_q;

    // Bit FSM and frame registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_rx_q <= StOcioso;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            dados_q     <= '0;
            paridade_q  <= 1'b0;
            parada_q    <= 1'b0;
            fim_q       <= 1'b0;
            char_ok_q   <= 1'b0;
            char_err_q  <= 1'b0;
        end else begin
            estado_rx_q <= estado_rx_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            dados_q     <= dados_d;
            paridade_q  <= paridade_d;
            parada_q    <= parada_d;
            fim_q       <= fim_d;
            char_ok_q   <= char_ok_d;
            char_err_q  <= char_err_d;
        end
    end

    // Bit FSM next state: mid-bit sampling, LSB first, odd parity, stop check
    always_comb begin
        estado_rx_d = estado_rx_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        dados_d     = dados_q;
        paridade_d  = paridade_q;
        parada_d    = parada_q;
        fim_d       = fim_q;
        char_ok_d   = 1'b0;
        char_err_d  = 1'b0;
        case (estado_rx_q)
            StOcioso: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                fim_d     = 1'b0;
                if (!linha) begin
                    estado_rx_d = StInicio;
                end
            end
            StInicio: begin
                if (cnt_q == HalfMax) begin
                    cnt_d       = '0;
                    // A start bit that is high again at mid-bit was a glitch
                    estado_rx_d = linha ? StOcioso : StDados;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDados: begin
                if (cnt_q == BitMax) begin
                    cnt_d   = '0;
                    dados_d = {linha, dados_q[6:1]};
                    if (bit_idx_q == 3'd6) begin
                        estado_rx_d = StParidade;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParidade: begin
                if (cnt_q == BitMax) begin
                    cnt_d       = '0;
                    paridade_d  = linha;
                    estado_rx_d = StParada;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParada: begin
                if (fim_q) begin
                    // Cycle after the stop sample: issue the character verdict
                    fim_d       = 1'b0;
                    estado_rx_d = StOcioso;
                    if ((^{dados_q, paridade_q}) && parada_q) begin
                        char_ok_d = 1'b1;
                    end else begin
                        char_err_d = 1'b1;
                    end
                end else if (cnt_q == BitMax) begin
                    cnt_d    = '0;
                    parada_d = linha;
                    fim_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                estado_rx_d = StOcioso;
            end
        endcase
    end

    assign eh_digito = (dados_q >= 7'h30) && (dados_q <= 7'h39);
    assign eh_hash   = (dados_q == 7'h23);
    assign digito    = dados_q[3:0];

    // Message FSM, shadow digits and committed outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msg_q    <= MsgC;
            cen_sh_q <= '0;
            dez_sh_q <= '0;
            uni_sh_q <= '0;
            cen_q    <= '0;
            dez_q    <= '0;
            uni_q    <= '0;
            pronta_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            msg_q    <= msg_d;
            cen_sh_q <= cen_sh_d;
            dez_sh_q <= dez_sh_d;
            uni_sh_q <= uni_sh_d;
            cen_q    <= cen_d;
            dez_q    <= dez_d;
            uni_q    <= uni_d;
            pronta_q <= pronta_d;
            erro_q   <= erro_d;
        end
    end

    // Message next state: digits fill the shadow, '#' commits, anything else resyncs
    always_comb begin
        msg_d    = msg_q;
        cen_sh_d = cen_sh_q;
        dez_sh_d = dez_sh_q;
        uni_sh_d = uni_sh_q;
        cen_d    = cen_q;
        dez_d    = dez_q;
        uni_d    = uni_q;
        pronta_d = 1'b0;
        erro_d   = 1'b0;
        if (char_err_q) begin
            erro_d = 1'b1;
            msg_d  = MsgC;
        end else if (char_ok_q) begin
            unique case (msg_q)
                MsgC: begin
                    if (eh_digito) begin
                        cen_sh_d = digito;
                        msg_d    = MsgD;
                    end else begin
                        erro_d = 1'b1;
                        msg_d  = MsgC;
                    end
                end
                MsgD: begin
                    if (eh_digito) begin
                        dez_sh_d = digito;
                        msg_d    = MsgU;
                    end else begin
                        erro_d = 1'b1;
                        msg_d  = MsgC;
                    end
                end
                MsgU: begin
                    if (eh_digito) begin
                        uni_sh_d = digito;
                        msg_d    = MsgHash;
                    end else begin
                        erro_d = 1'b1;
                        msg_d  = MsgC;
                    end
                end
                MsgHash: begin
                    if (eh_hash) begin
                        cen_d    = cen_sh_q;
                        dez_d    = dez_sh_q;
                        uni_d    = uni_sh_q;
                        pronta_d = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                    msg_d = MsgC;
                end
            endcase
        end
    end

    assign centena       = cen_q;
    assign dezena        = dez_q;
    assign unidade       = uni_q;
    assign medida_pronta = pronta_q;
    assign erro          = erro_q;
    assign db_estado_rx  = estado_rx_q;
    assign db_estado_msg = msg_q;

endmodule

// File: tb/tb_trena_receptor_medida.sv
// Bench for trena_receptor_medida: directed scenarios plus random messages,
// checked against a message-level reference model.
module tb_trena_receptor_medida;

    localparam int unsigned Cpb = 8;

    logic       clock;
    logic       reset;
    logic       entrada_serial;
    logic [3:0] centena, dezena, unidade;
    logic       medida_pronta, erro;
    logic [2:0] db_estado_rx;
    logic [1:0] db_estado_msg;

    int n_pass  = 0;
    int n_total = 0;

    // Pulse and state observations gathered on the falling edge
    int pronta_cnt = 0;
    int erro_cnt   = 0;
    int both_cnt   = 0;
    int inicio_cnt = 0;

    // Reference model state
    int         exp_pronta = 0;
    int         exp_erro   = 0;
    logic [3:0] exp_c = 4'd0, exp_d = 4'd0, exp_u = 4'd0;
    logic [6:0] msg_buf[$];

    trena_receptor_medida #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .entrada_serial(entrada_serial),
        .centena       (centena),
        .dezena        (dezena),
        .unidade       (unidade),
        .medida_pronta (medida_pronta),
        .erro          (erro),
        .db_estado_rx  (db_estado_rx),
        .db_estado_msg (db_estado_msg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (medida_pronta === 1'b1) pronta_cnt++;
        if (erro === 1'b1) erro_cnt++;
        if (medida_pronta === 1'b1 && erro === 1'b1) both_cnt++;
        if (db_estado_rx === 3'd1) inicio_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One 7O1 frame; bad_par flips parity, bad_stop drives the first stop bit low
    task automatic send_frame(input logic [6:0] c, input bit bad_par, input bit bad_stop,
                              input int nstop);
        logic p;
        p = (~^c) ^ bad_par;
        entrada_serial = 1'b0;
        wait_clk(Cpb);
        for (int i = 0; i < 7; i++) begin
            entrada_serial = c[i];
            wait_clk(Cpb);
        end
        entrada_serial = p;
        wait_clk(Cpb);
        entrada_serial = !bad_stop;
        wait_clk(Cpb);
        for (int i = 1; i < nstop; i++) begin
            entrada_serial = 1'b1;
            wait_clk(Cpb);
        end
        entrada_serial = 1'b1;
    endtask

    function automatic bit is_digit(input logic [6:0] c);
        return (c >= 7'h30) && (c <= 7'h39);
    endfunction

    // Message rule: accepted text since the last resync must be a prefix of "DDD#"
    task automatic model_char(input logic [6:0] c, input bit bad);
        int  pos;
        bit  fits;
        if (bad) begin
            exp_erro++;
            msg_buf.delete();
        end else begin
            pos  = msg_buf.size();
            fits = (pos < 3) ? is_digit(c) : (c == 7'h23);
            if (!fits) begin
                exp_erro++;
                msg_buf.delete();
            end else if (pos == 3) begin
                exp_pronta++;
                exp_c = 4'(msg_buf[0] - 7'h30);
                exp_d = 4'(msg_buf[1] - 7'h30);
                exp_u = 4'(msg_buf[2] - 7'h30);
                msg_buf.delete();
            end else begin
                msg_buf.push_back(c);
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " pronta"}, 32'(pronta_cnt), 32'(exp_pronta));
        check({tag, " erro"}, 32'(erro_cnt), 32'(exp_erro));
        check({tag, " digitos"}, 32'({centena, dezena, unidade}), 32'({exp_c, exp_d, exp_u}));
        check({tag, " estado_msg"}, 32'(db_estado_msg), 32'(msg_buf.size()));
    endtask

    task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop);
        send_frame(c, bad_par, bad_stop, 2);
        model_char(c, bad_par | bad_stop);
        check_all($sformatf("char 0x%0h", c));
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0], 1'b0, 1'b0);
        end
    endtask

    initial begin
        int         snap;
        int         n;
        logic [6:0] c;
        bit         bp, bs;
        byte        b;

        reset          = 1'b0;
        entrada_serial = 1'b1;
        wait_clk(3);
        check("reset digitos", 32'({centena, dezena, unidade}), 32'h0);
        check("reset pulsos", 32'({medida_pronta, erro}), 32'h0);
        check("reset estado_rx", 32'(db_estado_rx), 32'h0);
        check("reset estado_msg", 32'(db_estado_msg), 32'h0);
        reset = 1'b1;
        wait_clk(5);

        // Plain message
        send_str("123#");

        // Parity error in the middle of a message, then a clean one
        send_char(7'h34, 1'b0, 1'b0);
        send_char(7'h35, 1'b1, 1'b0);
        send_str("6#");
        send_str("045#");

        // Short low glitch on the idle line
        snap = inicio_cnt;
        entrada_serial = 1'b0;
        wait_clk(3);
        entrada_serial = 1'b1;
        wait_clk(12);
        check("glitch viu inicio", 32'(inicio_cnt > snap), 32'h1);
        check("glitch estado_rx", 32'(db_estado_rx), 32'h0);
        check_all("glitch");

        // Short message, then a good one
        send_str("12#");
        send_str("789#");

        // Framing error, then a good message
        send_char(7'h39, 1'b0, 1'b1);
        send_str("321#");

        // Back-to-back frames with a single stop bit and no idle time
        for (int i = 0; i < 4; i++) begin
            c = (i == 3) ? 7'h23 : 7'(7'h36 - i);
            send_frame(c, 1'b0, 1'b0, 1);
            model_char(c, 1'b0);
        end
        wait_clk(2 * Cpb);
        check_all("sem folga");

        // Reset in the middle of the second character of "555#"
        send_char(7'h35, 1'b0, 1'b0);
        c = 7'h35;
        entrada_serial = 1'b0;
        wait_clk(Cpb);
        for (int i = 0; i < 3; i++) begin
            entrada_serial = c[i];
            wait_clk(Cpb);
        end
        reset = 1'b0;
        #1;
        msg_buf.delete();
        exp_c = 4'd0;
        exp_d = 4'd0;
        exp_u = 4'd0;
        check("reset meio digitos", 32'({centena, dezena, unidade}), 32'h0);
        check("reset meio estado_rx", 32'(db_estado_rx), 32'h0);
        check("reset meio estado_msg", 32'(db_estado_msg), 32'h0);
        entrada_serial = 1'b1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(20);
        check_all("apos reset");
        send_str("987#");

        // Random traffic: mostly well-formed messages with occasional corruption
        for (int m = 0; m < 12; m++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 4; k++) begin
                    c  = (k == 3) ? 7'h23 : 7'(7'h30 + $urandom_range(0, 9));
                    bp = ($urandom_range(0, 15) == 0);
                    bs = ($urandom_range(0, 15) == 1);
                    send_char(c, bp, bs);
                end
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    case ($urandom_range(0, 3))
                        0, 1:    c = 7'(7'h30 + $urandom_range(0, 9));
                        2:       c = 7'h23;
                        default: c = 7'($urandom_range(0, 127));
                    endcase
                    send_char(c, 1'b0, 1'b0);
                end
            end
            wait_clk($urandom_range(0, 5));
        end

        check("pulsos exclusivos", 32'(both_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
